modmul_iter: RTL and testbench
==============================

Name: modmul_iter

Overview:
- Iterative radix-2 shift-add multiplier for two LOGQ-bit residues.
- Produces the full 2*LOGQ-bit product that feeds the combinational `modred` stage directly downstream.
- Uses valid/ready handshakes on both sides and a fixed latency, so butterfly and control logic can schedule around it.
- Carries an opaque tag (coefficient index) alongside each operation.

Parameters:
- LOGQ, 17, operand bit width; product width is 2*LOGQ.
- Q, 65537, modulus; documentation and assertion bound only, no arithmetic use.
- TAGW, 8, width of the pass-through tag.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and tag valid.
- in_ready  output  1  block can accept an operation.
- a  input  LOGQ  multiplicand, residue < Q.
- b  input  LOGQ  multiplier, residue < Q.
- in_tag  input  TAGW  opaque tag.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream (`modred`) accepts the product.
- p  output  2*LOGQ  product a*b, exact, unreduced.
- out_tag  output  TAGW  tag captured with the operands.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, in_ready=1, out_valid=0, p=0, out_tag=0, internal acc/mcand/mplier/count=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at an edge: acc<=0, mcand<=zero-extended a (2*LOGQ bits), mplier<=b, tag<=in_tag, count<=0, state<=RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: if mplier[0], acc<=acc+mcand (2*LOGQ-bit add, no overflow possible for LOGQ-bit operands); mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - When count==LOGQ-1 the final iteration executes, then state<=DONE.
  - Exactly LOGQ RUN cycles regardless of operand values; no early exit.
- DONE:
  - out_valid=1, p=acc, out_tag=tag; both held stable while out_ready=0.
  - On out_valid&&out_ready: state<=IDLE.
- Latency: acceptance edge E0 → out_valid first high in the cycle after edge E0+LOGQ. Throughput: one operation per LOGQ+2 cycles minimum.
- No overlap: a new operation is never accepted while in RUN or DONE, including the DONE→IDLE handoff cycle. in_ready is a pure function of state.
- in_valid while in_ready=0 is ignored. Upstream must hold its data; the block never latches it.
- Backpressure: out_ready low indefinitely keeps DONE; p and out_tag do not change.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The in-flight operation is discarded and no out_valid pulse is produced.
- Counter width: $clog2(LOGQ)+1 bits.
- Operands ≥ Q: product still computed exactly over integers; a simulation-only assertion flags a>=Q or b>=Q at acceptance.
- Boundary: (Q-1)*(Q-1) for Q=65537 is 2^32, which fits in 34 bits.

Decomposition:
- Shared include file ntt_params.vh holds:
  - LOGQ and Q defaults;
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the product-width localparam PW=2*LOGQ.
- One natural sub-module: mul_step, a combinational single shift-add iteration (acc, mcand, mplier → next acc, mcand, mplier).
- The FSM, counter and handshake stay in modmul_iter.
- modred is not instantiated here; integration connects p to modred.a at the next level up.

Test Plan:
- a=2, b=3, tag=0x11 accepted at edge E0 → out_valid high after edge E0+17, p=6, out_tag=0x11; in_ready=0 throughout RUN and DONE.
- a=65536, b=65536 → p=0x1_0000_0000 (4294967296); fed into modred yields s=1.
- a=0, b=65535 and a=12345, b=1 → p=0 and p=12345 respectively, each after exactly 17 RUN cycles.
- a=300, b=400 completes with out_ready held low for 10 cycles → out_valid, p=120000 and out_tag stable for all 10 cycles; one transfer on out_ready rise; in_ready returns to 1 on the following cycle.
- rst pulsed at RUN cycle 5 of a=7, b=9 → all outputs return to reset values asynchronously; no out_valid follows. Next op a=5, b=5 → p=25.
- 50 back-to-back random residue pairs with in_valid held high and out_ready=1 → each p matches the a*b model and tags stay in order. Accepted-handshake spacing is exactly 19 cycles.

Source files
------------

// File: rtl/modmul_iter_pkg.sv
// -----------------------------------------------------------------------------
// modmul_iter_pkg
//   Shared constants for the iterative modular-multiplier slice.
//   - Default operand width and modulus for the NTT datapath.
//   - FSM state encoding used by modmul_iter. These are plain localparams
//     because legacy control logic decodes the raw 2-bit value.
//   - Default product width (two operand widths).
// -----------------------------------------------------------------------------
package modmul_iter_pkg;

    // Default residue width and modulus (Q = 2^16 + 1).
    localparam int LOGQ_DEF = 17;
    localparam int Q_DEF    = 65537;
    localparam int TAGW_DEF = 8;

    // Full, unreduced product width for the default operand width.
    localparam int PW_DEF   = 2 * LOGQ_DEF;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : modmul_iter_pkg

// File: rtl/modmul_iter_chk.sv
// -----------------------------------------------------------------------------
// modmul_iter_chk
//   Simulation-only property checker for modmul_iter.
//   Ports:
//     clk, rst - clock and asynchronous active-high reset of the checked block
//     accept   - operand handshake (in_valid && in_ready) of the checked block
//     a, b     - operands presented with the handshake
//   Flags any accepted operand that is not a reduced residue (>= Q). The block
//   still multiplies such operands exactly; the flag exists because the
//   downstream reduction stage assumes reduced inputs.
// -----------------------------------------------------------------------------
module modmul_iter_chk #(
    parameter int LOGQ = 17,
    parameter int Q    = 65537
) (
    input logic            clk,
    input logic            rst,
    input logic            accept,
    input logic [LOGQ-1:0] a,
    input logic [LOGQ-1:0] b
);

    // Q widened by one bit so a full LOGQ-bit operand compares cleanly.
    localparam logic [LOGQ:0] Q_EXT = (LOGQ + 1)'(Q);

    // Operands must be reduced residues at the acceptance edge.
    a_operand_residue : assert property (
        @(posedge clk) disable iff (rst)
        accept |-> (({1'b0, a} < Q_EXT) && ({1'b0, b} < Q_EXT))
    );

endmodule : modmul_iter_chk

// File: rtl/mul_step.sv
// -----------------------------------------------------------------------------
// mul_step
//   One combinational radix-2 shift-add iteration.
//   Ports:
//     acc        - running partial product (PW bits)
//     mcand      - multiplicand, already shifted to the current bit weight
//     mplier     - remaining multiplier bits; bit 0 is the bit consumed now
//     acc_nxt    - acc + mcand when mplier[0] is set, else acc
//     mcand_nxt  - mcand shifted left by one (next bit weight)
//     mplier_nxt - mplier shifted right by one (exposes the next bit)
// -----------------------------------------------------------------------------
module mul_step #(
    parameter int LOGQ = 17,
    parameter int PW   = 2 * LOGQ
) (
    input  logic [PW-1:0]   acc,
    input  logic [PW-1:0]   mcand,
    input  logic [LOGQ-1:0] mplier,
    output logic [PW-1:0]   acc_nxt,
    output logic [PW-1:0]   mcand_nxt,
    output logic [LOGQ-1:0] mplier_nxt
);

    // Conditional add of the current partial product plus operand shifts.
    // The accumulator cannot overflow: the sum of LOGQ shifted LOGQ-bit
    // terms always fits in 2*LOGQ bits.
    always_comb begin
        acc_nxt    = acc;
        mcand_nxt  = {mcand[PW-2:0], 1'b0};
        mplier_nxt = {1'b0, mplier[LOGQ-1:1]};
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end else begin
            acc_nxt = acc;
        end
    end

endmodule : mul_step

// File: rtl/modmul_iter.sv
// -----------------------------------------------------------------------------
// modmul_iter
//   Iterative radix-2 shift-add multiplier producing the exact 2*LOGQ-bit
//   product of two LOGQ-bit residues. Fixed latency, no early exit: every
//   operation spends exactly LOGQ cycles in RUN so that butterfly control can
//   schedule around it. An opaque tag travels with each operation.
//
//   Ports:
//     clk       - rising-edge clock
//     rst       - asynchronous active-high reset
//     in_valid  - operand pair and tag valid
//     in_ready  - block idle and able to accept an operation
//     a, b      - multiplicand / multiplier (residues < Q)
//     in_tag    - opaque tag captured with the operands
//     out_valid - product valid (held until out_ready)
//     out_ready - downstream reduction stage accepts the product
//     p         - a*b, exact, unreduced (2*LOGQ bits)
//     out_tag   - tag captured with the operands
//
//   Timing: acceptance edge E0 -> out_valid high after edge E0+LOGQ.
//   The DONE->IDLE handoff takes one edge, so back-to-back operations are
//   spaced LOGQ+2 cycles apart.
// -----------------------------------------------------------------------------
module modmul_iter
    import modmul_iter_pkg::*;
#(
    parameter int LOGQ = LOGQ_DEF,
    parameter int Q    = Q_DEF,
    parameter int TAGW = TAGW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LOGQ-1:0]   a,
    input  logic [LOGQ-1:0]   b,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*LOGQ-1:0] p,
    output logic [TAGW-1:0]   out_tag
);

    localparam int PW = 2 * LOGQ;
    localparam int CW = $clog2(LOGQ) + 1;
    // Count value during which the final iteration executes.
    localparam logic [CW-1:0] LAST_CNT = CW'(LOGQ - 1);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [PW-1:0]   acc_r;
    logic [PW-1:0]   mcand_r;
    logic [LOGQ-1:0] mplier_r;
    logic [CW-1:0]   count_r;
    logic [TAGW-1:0] tag_r;
    logic            in_ready_r;
    logic            out_valid_r;

    logic [PW-1:0]   step_acc_s;
    logic [PW-1:0]   step_mcand_s;
    logic [LOGQ-1:0] step_mplier_s;
    logic            accept_s;
    logic            xfer_s;
    logic            last_s;

    assign accept_s = in_valid && in_ready_r;
    assign xfer_s   = out_valid_r && out_ready;
    assign last_s   = (count_r == LAST_CNT);

    // Outputs come straight from registers. The handshake flags are kept as
    // registered copies of the state decode, so they remain a pure function
    // of state without any combinational path from the inputs.
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign p         = acc_r;
    assign out_tag   = tag_r;

    // Single shift-add iteration on the current datapath registers.
    mul_step #(
        .LOGQ (LOGQ),
        .PW   (PW)
    ) u_mul_step (
        .acc        (acc_r),
        .mcand      (mcand_r),
        .mplier     (mplier_r),
        .acc_nxt    (step_acc_s),
        .mcand_nxt  (step_mcand_s),
        .mplier_nxt (step_mplier_s)
    );

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (xfer_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                // Unreachable encoding: recover to the safe idle state.
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Datapath: operand capture on acceptance, one iteration per RUN cycle,
    // hold everything in DONE so p and out_tag stay stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {LOGQ{1'b0}};
            count_r  <= {CW{1'b0}};
            tag_r    <= {TAGW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r    <= {PW{1'b0}};
                        mcand_r  <= {{(PW - LOGQ){1'b0}}, a};
                        mplier_r <= b;
                        count_r  <= {CW{1'b0}};
                        tag_r    <= in_tag;
                    end
                end
                ST_RUN: begin
                    acc_r    <= step_acc_s;
                    mcand_r  <= step_mcand_s;
                    mplier_r <= step_mplier_s;
                    count_r  <= count_r + {{(CW - 1){1'b0}}, 1'b1};
                end
                ST_DONE: begin
                    // Hold result and tag until the downstream transfer.
                end
                default: begin
                    // Unreachable encoding: datapath holds; FSM recovers.
                end
            endcase
        end
    end

    // Simulation-only residue-range check at acceptance.
    modmul_iter_chk #(
        .LOGQ (LOGQ),
        .Q    (Q)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .accept (accept_s),
        .a      (a),
        .b      (b)
    );

endmodule : modmul_iter

// File: tb/tb_modmul_iter.sv
// -----------------------------------------------------------------------------
// tb_modmul_iter
//   Directed, self-checking bench for modmul_iter (LOGQ=17, Q=65537, TAGW=8).
// -----------------------------------------------------------------------------
module tb_modmul_iter;

    localparam int LOGQ = 17;
    localparam int TAGW = 8;
    localparam int PW   = 2 * LOGQ;
    localparam int NB2B = 50;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] a;
    logic [LOGQ-1:0] b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   p;
    logic [TAGW-1:0] out_tag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    modmul_iter #(
        .LOGQ (LOGQ),
        .Q    (65537),
        .TAGW (TAGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Present one operation at a negedge; it is accepted on the next posedge.
    task automatic start_op(input logic [LOGQ-1:0] av, input logic [LOGQ-1:0] bv,
                            input logic [TAGW-1:0] tv);
        @(negedge clk);
        a = av; b = bv; in_tag = tv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count negedges after the acceptance edge until out_valid; note in_ready.
    task automatic wait_valid(output int n, output bit to, output bit saw_ready);
        n = 0; to = 1'b0; saw_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) saw_ready = 1'b1;
            n++;
            if (n > 100) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; in_tag = '0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (p !== 34'd0) begin errors++; $display("FAIL reset_p: got %0d want 0", p); end
        checks++; if (out_tag !== 8'h00) begin errors++; $display("FAIL reset_out_tag: got %h want 00", out_tag); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int n; bit to; bit sr;
        start_op(17'd2, 17'd3, 8'h11);
        wait_valid(n, to, sr);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", to); end
        checks++; if (n !== 17) begin errors++; $display("FAIL basic_latency: got %0d want 17", n); end
        checks++; if (p !== 34'd6) begin errors++; $display("FAIL basic_p: got %0d want 6", p); end
        checks++; if (out_tag !== 8'h11) begin errors++; $display("FAIL basic_tag: got %h want 11", out_tag); end
        checks++; if (sr !== 1'b0) begin errors++; $display("FAIL basic_ready_in_run: got %b want 0", sr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_boundary();
        int n; bit to; bit sr;
        start_op(17'd65536, 17'd65536, 8'h22);
        wait_valid(n, to, sr);
        checks++; if (n !== 17 || to) begin errors++; $display("FAIL max_latency: got %0d want 17", n); end
        checks++; if (p !== 34'h1_0000_0000) begin errors++; $display("FAIL max_p: got %h want 100000000", p); end
        checks++; if (out_tag !== 8'h22) begin errors++; $display("FAIL max_tag: got %h want 22", out_tag); end
        @(negedge clk);
        start_op(17'd0, 17'd65535, 8'h23);
        wait_valid(n, to, sr);
        checks++; if (n !== 17 || to) begin errors++; $display("FAIL zero_latency: got %0d want 17", n); end
        checks++; if (p !== 34'd0) begin errors++; $display("FAIL zero_p: got %0d want 0", p); end
        @(negedge clk);
        start_op(17'd12345, 17'd1, 8'h24);
        wait_valid(n, to, sr);
        checks++; if (n !== 17 || to) begin errors++; $display("FAIL one_latency: got %0d want 17", n); end
        checks++; if (p !== 34'd12345) begin errors++; $display("FAIL one_p: got %0d want 12345", p); end
        checks++; if (out_tag !== 8'h24) begin errors++; $display("FAIL one_tag: got %h want 24", out_tag); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n; bit to; bit sr;
        out_ready = 1'b0;
        start_op(17'd300, 17'd400, 8'h33);
        wait_valid(n, to, sr);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", to); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (p !== 34'd120000) begin errors++; $display("FAIL bp_p[%0d]: got %0d want 120000", i, p); end
            checks++; if (out_tag !== 8'h33) begin errors++; $display("FAIL bp_tag[%0d]: got %h want 33", i, out_tag); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            if (i < 9) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_xfer: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_run();
        int n; bit to; bit sr; bit seen;
        start_op(17'd7, 17'd9, 8'h44);
        repeat (5) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rr_in_run: got %b want 0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_out_valid: got %b want 0", out_valid); end
        checks++; if (p !== 34'd0) begin errors++; $display("FAIL rr_p: got %0d want 0", p); end
        checks++; if (out_tag !== 8'h00) begin errors++; $display("FAIL rr_tag: got %h want 00", out_tag); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rr_no_valid: got %b want 0", seen); end
        start_op(17'd5, 17'd5, 8'h55);
        wait_valid(n, to, sr);
        checks++; if (n !== 17 || to) begin errors++; $display("FAIL rr_next_latency: got %0d want 17", n); end
        checks++; if (p !== 34'd25) begin errors++; $display("FAIL rr_next_p: got %0d want 25", p); end
        checks++; if (out_tag !== 8'h55) begin errors++; $display("FAIL rr_next_tag: got %h want 55", out_tag); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [LOGQ-1:0] av [NB2B];
        logic [LOGQ-1:0] bv [NB2B];
        int acc_cyc [NB2B];
        int got;
        for (int i = 0; i < NB2B; i++) begin
            av[i] = LOGQ'($urandom_range(0, 65536));
            bv[i] = LOGQ'($urandom_range(0, 65536));
        end
        got = 0;
        out_ready = 1'b1;
        fork
            begin : driver
                @(negedge clk);
                for (int i = 0; i < NB2B; i++) begin
                    int w;
                    a = av[i]; b = bv[i]; in_tag = TAGW'(i); in_valid = 1'b1;
                    w = 0;
                    while (!in_ready && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 100) begin
                        checks++; errors++;
                        $display("FAIL b2b_accept_timeout[%0d]: waited %0d cycles, limit 100", i, w);
                        break;
                    end
                    @(posedge clk);
                    #1 acc_cyc[i] = cyc;
                    if (i > 0) begin
                        checks++;
                        if (acc_cyc[i] - acc_cyc[i-1] !== 19) begin
                            errors++;
                            $display("FAIL b2b_spacing[%0d]: got %0d want 19", i, acc_cyc[i] - acc_cyc[i-1]);
                        end
                    end
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin : monitor
                for (int k = 0; k < NB2B * 19 + 200 && got < NB2B; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        logic [PW-1:0] expv;
                        expv = PW'(av[got]) * PW'(bv[got]);
                        checks++;
                        if (p !== expv) begin errors++; $display("FAIL b2b_p[%0d]: got %0d want %0d", got, p, expv); end
                        checks++;
                        if (out_tag !== TAGW'(got)) begin errors++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", got, out_tag, got); end
                        got++;
                    end
                end
            end
        join
        checks++; if (got !== NB2B) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got, NB2B); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_modmul_iter
